fft_input_reorder: RTL and testbench



---
 rtl/fft_pkg.sv | 17 +
 rtl/fft_input_reorder_if.sv | 32 +++
 rtl/fft_sample_bank.sv | 43 ++++
 rtl/fft_input_reorder.sv | 106 ++++++++++
 tb/tb_fft_input_reorder.sv | 194 +++++++++++++++++++
 5 files changed

// File: rtl/fft_pkg.sv
// Shared constants and helpers for the 8-point FFT input reorder path.
// W is derived from N as 2**N; bitrev3 maps time index to butterfly slot.
package fft_pkg;

  localparam int POINTS = 8;
  localparam int ADDR_W = 3;

  function automatic int sample_width(input int n);
    return 2 ** n;
  endfunction

  // Slot order x0,x4,x2,x6,x1,x5,x3,x7 for time indices 0..7.
  function automatic logic [ADDR_W-1:0] bitrev3(input logic [ADDR_W-1:0] j);
    return {j[0], j[1], j[2]};
  endfunction

endpackage

// File: rtl/fft_input_reorder_if.sv
// Sample-in / frame-out handshake bundle for fft_input_reorder.
// The slave modport is the reorder block's view; master is the environment's.
interface fft_input_reorder_if #(
  parameter int W = 8
);

  logic                  in_valid;
  logic                  in_ready;
  logic signed [W-1:0]   in_data;
  logic                  out_valid;
  logic                  out_ready;
  logic [8*W-1:0]        out_r;

  modport slave (
    input  in_valid,
    input  in_data,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_r
  );

  modport master (
    output in_valid,
    output in_data,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_r
  );

endinterface

// File: rtl/fft_sample_bank.sv
// One frame buffer: POINTS signed samples, single write port, whole frame
// visible on a packed read bus (slot k at bits [k*W +: W]).
module fft_sample_bank
  import fft_pkg::*;
#(
  parameter int W = 8
) (
  input  logic                   clk,
  input  logic                   clr,
  input  logic                   we,
  input  logic [ADDR_W-1:0]      waddr,
  input  logic signed [W-1:0]    wdata,
  output logic [POINTS*W-1:0]    rdata
);

  logic signed [W-1:0] mem_q [POINTS];
  logic signed [W-1:0] mem_d [POINTS];

  always_comb begin
    mem_d = mem_q;
    if (we) begin
      mem_d[waddr] = wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < POINTS; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      mem_q <= mem_d;
    end
  end

  always_comb begin
    rdata = '0;
    for (int i = 0; i < POINTS; i++) begin
      rdata[i*W +: W] = mem_q[i];
    end
  end

endmodule

// File: rtl/fft_input_reorder.sv
// Ping-pong input buffer for an 8-point FFT: samples arrive in time order,
// land in bit-reversed slots, and complete frames are handed out whole.
module fft_input_reorder #(
  parameter int N      = 3,
  parameter int POINTS = 8
) (
  input  logic              clk,
  input  logic              rst,
  fft_input_reorder_if.slave bus
);

  import fft_pkg::*;

  localparam int W = sample_width(N);

  logic [ADDR_W-1:0]     cnt_q, cnt_d;
  logic                  wr_bank_q, wr_bank_d;
  logic                  rd_bank_q, rd_bank_d;
  logic [1:0]            full_q, full_d;

  logic                  in_ready;
  logic                  out_valid;
  logic                  accept;
  logic                  consume;
  logic                  frame_done;
  logic [1:0]            bank_we;
  logic [ADDR_W-1:0]     wr_addr;
  logic [POINTS*W-1:0]   bank0_rd;
  logic [POINTS*W-1:0]   bank1_rd;

  always_comb begin
    in_ready   = ~full_q[wr_bank_q];
    out_valid  = full_q[rd_bank_q];
    accept     = bus.in_valid & in_ready;
    consume    = out_valid & bus.out_ready;
    frame_done = accept && (cnt_q == ADDR_W'(POINTS - 1));
    wr_addr    = bitrev3(cnt_q);
    bank_we    = '0;
    bank_we[wr_bank_q] = accept;
  end

  // Completion and consume always target different banks (the write bank is
  // never full while accepting, the read bank always is), so both may land
  // on the same edge without conflict.
  always_comb begin
    cnt_d     = cnt_q;
    wr_bank_d = wr_bank_q;
    rd_bank_d = rd_bank_q;
    full_d    = full_q;
    if (accept) begin
      cnt_d = cnt_q + ADDR_W'(1);
    end
    if (frame_done) begin
      full_d[wr_bank_q] = 1'b1;
      wr_bank_d         = ~wr_bank_q;
    end
    if (consume) begin
      full_d[rd_bank_q] = 1'b0;
      rd_bank_d         = ~rd_bank_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q     <= '0;
      wr_bank_q <= 1'b0;
      rd_bank_q <= 1'b0;
      full_q    <= '0;
    end else begin
      cnt_q     <= cnt_d;
      wr_bank_q <= wr_bank_d;
      rd_bank_q <= rd_bank_d;
      full_q    <= full_d;
    end
  end

  fft_sample_bank #(.W(W)) u_bank0 (
    .clk   (clk),
    .clr   (rst),
    .we    (bank_we[0]),
    .waddr (wr_addr),
    .wdata (bus.in_data),
    .rdata (bank0_rd)
  );

  fft_sample_bank #(.W(W)) u_bank1 (
    .clk   (clk),
    .clr   (rst),
    .we    (bank_we[1]),
    .waddr (wr_addr),
    .wdata (bus.in_data),
    .rdata (bank1_rd)
  );

  // The frame is blanked while not valid so that a bank still being filled
  // never leaks partial contents onto out_r.
  always_comb begin
    bus.in_ready  = in_ready;
    bus.out_valid = out_valid;
    bus.out_r     = '0;
    if (out_valid) begin
      bus.out_r = rd_bank_q ? bank1_rd : bank0_rd;
    end
  end

endmodule

// File: tb/tb_fft_input_reorder.sv
// Bench for fft_input_reorder: fixed vector table, directed corner sequences,
// and randomized traffic against a frame-queue reference model.
module tb_fft_input_reorder;

  localparam int W = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  fft_input_reorder_if #(.W(W)) bus ();

  fft_input_reorder #(.N(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Packs values given in slot order 0..7 into the 64-bit frame layout.
  function automatic logic [63:0] pk8(input int s0, input int s1, input int s2, input int s3,
                                      input int s4, input int s5, input int s6, input int s7);
    return {s7[7:0], s6[7:0], s5[7:0], s4[7:0], s3[7:0], s2[7:0], s1[7:0], s0[7:0]};
  endfunction

  // Reference model: completed frames wait in a queue (at most two can be
  // held); samples of the frame in progress collect in time order.
  logic [63:0] mq[$];
  logic [7:0]  cur[8];
  int          mcnt;

  function automatic int brev(input int j);
    return ((j & 1) << 2) | (j & 2) | ((j >> 2) & 1);
  endfunction

  task automatic model_clear();
    mq.delete();
    mcnt = 0;
  endtask

  logic        obs_rdy, obs_vld;
  logic [63:0] obs_out;
  int          obs_acc, obs_del;

  task automatic cycle(input logic v, input logic [7:0] d, input logic ordy, input string tag);
    logic        e_rdy, e_vld, acc, cons;
    logic [63:0] e_out, f;
    bus.in_valid  = v;
    bus.in_data   = d;
    bus.out_ready = ordy;
    @(negedge clk);
    e_rdy = (mq.size() < 2);
    e_vld = (mq.size() > 0);
    e_out = e_vld ? mq[0] : 64'd0;
    obs_rdy = bus.in_ready;
    obs_vld = bus.out_valid;
    obs_out = bus.out_r;
    if (v && obs_rdy) obs_acc++;
    if (obs_vld && ordy) obs_del++;
    chk({tag, ".in_ready"}, 64'(obs_rdy), 64'(e_rdy));
    chk({tag, ".out_valid"}, 64'(obs_vld), 64'(e_vld));
    chk({tag, ".out_r"}, obs_out, e_out);
    acc  = v && e_rdy;
    cons = e_vld && ordy;
    @(posedge clk);
    if (cons) void'(mq.pop_front());
    if (acc) begin
      cur[mcnt] = d;
      mcnt++;
      if (mcnt == 8) begin
        f = '0;
        for (int j = 0; j < 8; j++) f[brev(j)*8 +: 8] = cur[j];
        mq.push_back(f);
        mcnt = 0;
      end
    end
    #1;
  endtask

  task automatic do_reset();
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_clear();
  endtask

  typedef struct {
    logic        v;
    logic [7:0]  d;
    logic        ordy;
    logic        e_rdy;
    logic        e_vld;
    logic [63:0] e_out;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic v, input int d, input logic ordy,
                     input logic er, input logic ev, input logic [63:0] eo);
    vec_t r;
    r.v = v; r.d = d[7:0]; r.ordy = ordy; r.e_rdy = er; r.e_vld = ev; r.e_out = eo;
    tbl.push_back(r);
  endtask

  initial begin
    int          vals [8];
    logic [63:0] fa, fb;

    // Table: values from reset, then two frames with out_ready high.
    add(0, 0, 1, 1, 0, 64'd0);
    for (int i = 0; i < 8; i++) add(1, (i + 1) * 10, 1, 1, 0, 64'd0);
    add(0, 0, 1, 1, 1, pk8(10, 50, 30, 70, 20, 60, 40, 80));
    add(0, 0, 1, 1, 0, 64'd0);
    vals = '{-128, 127, -1, 0, 1, -2, 2, -127};
    for (int i = 0; i < 8; i++) add(1, vals[i], 1, 1, 0, 64'd0);
    add(0, 0, 0, 1, 1, pk8(-128, 1, -1, 2, 127, -2, 0, -127));
    add(0, 0, 1, 1, 1, pk8(-128, 1, -1, 2, 127, -2, 0, -127));
    add(0, 0, 1, 1, 0, 64'd0);

    do_reset();
    for (int i = 0; i < tbl.size(); i++) begin
      bus.in_valid  = tbl[i].v;
      bus.in_data   = tbl[i].d;
      bus.out_ready = tbl[i].ordy;
      @(negedge clk);
      chk($sformatf("tbl%0d.in_ready", i), 64'(bus.in_ready), 64'(tbl[i].e_rdy));
      chk($sformatf("tbl%0d.out_valid", i), 64'(bus.out_valid), 64'(tbl[i].e_vld));
      chk($sformatf("tbl%0d.out_r", i), bus.out_r, tbl[i].e_out);
      @(posedge clk);
      #1;
    end

    // Back-pressure: 17 offered samples, two frames fit, the 17th is held off.
    do_reset();
    obs_acc = 0;
    for (int i = 0; i < 17; i++) begin
      cycle(1'b1, 8'(i + 1), 1'b0, $sformatf("hold%0d", i));
      if (i == 16) chk("hold.in_ready_c17", 64'(obs_rdy), 64'd0);
    end
    chk("hold.accepted", 64'(obs_acc), 64'd16);
    fa = pk8(1, 5, 3, 7, 2, 6, 4, 8);
    fb = pk8(9, 13, 11, 15, 10, 14, 12, 16);
    chk("hold.frame1_held", obs_out, fa);
    cycle(1'b0, 8'd0, 1'b1, "drain0");
    chk("drain.frame1", obs_out, fa);
    cycle(1'b0, 8'd0, 1'b1, "drain1");
    chk("drain.frame2", obs_out, fb);
    chk("drain.in_ready_after_consume", 64'(obs_rdy), 64'd1);
    cycle(1'b0, 8'd0, 1'b1, "drain2");

    // Streaming: 24 back-to-back samples with out_ready held high.
    do_reset();
    obs_del = 0;
    for (int i = 0; i < 24; i++) begin
      cycle(1'b1, 8'($urandom), 1'b1, $sformatf("strm%0d", i));
      chk($sformatf("strm%0d.no_stall", i), 64'(obs_rdy), 64'd1);
    end
    for (int i = 0; i < 3; i++) cycle(1'b0, 8'd0, 1'b1, "strm_tail");
    chk("strm.frames", 64'(obs_del), 64'd3);

    // Reset mid-frame discards the partial frame.
    do_reset();
    for (int i = 0; i < 5; i++) cycle(1'b1, 8'(100 + i), 1'b0, "pre_rst");
    do_reset();
    for (int i = 0; i < 8; i++) cycle(1'b1, 8'(i * 3 + 1), 1'b0, "post_rst");
    cycle(1'b0, 8'd0, 1'b1, "post_rst_out");
    chk("rst.new_frame", obs_out, pk8(1, 13, 7, 19, 4, 16, 10, 22));

    // Randomized traffic against the model, then a full drain.
    do_reset();
    for (int i = 0; i < 600; i++) begin
      cycle(1'($urandom_range(0, 3) != 0), 8'($urandom), 1'($urandom_range(0, 2) == 0), "rnd");
    end
    for (int i = 0; i < 4; i++) cycle(1'b0, 8'd0, 1'b1, "rnd_drain");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
